// File: rtl/sum_accumulator.sv
// Frame accumulator behind the 4-bit ripple adder: sums COUNT adder results, then offers the total on valid/ready.
// Build option SUM_ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(COUNT + 1);
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               xfer;
    logic [SUM_W-1:0]   sum_ext;
    logic [ACC_W-1:0]   add_res;
    logic               last_beat;

    // Source is held off while a finished total waits, and during rst/clr.
    assign in_ready  = (state != DONE) && !rst && !clr;
    assign xfer      = in_valid && in_ready;

    // One bit wider than the accumulator; the MSB flags overflow of this add.
    assign sum_ext   = {1'b0, acc_out} + SUM_W'(sum_in);
    assign last_beat = (cnt == CNT_W'(COUNT - 1));

`ifdef SUM_ACC_SATURATE_EN
    assign add_res = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign add_res = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state     <= IDLE;
            acc_out   <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        acc_out <= ACC_W'(sum_in);
                        cnt     <= CNT_W'(1);
                        ovf     <= 1'b0;
                        if (COUNT == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= ACCUM;
                            busy  <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_out <= add_res;
                        ovf     <= ovf | sum_ext[ACC_W];
                        cnt     <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // acc_out and ovf stay visible after the handshake.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: two lockstep instances (ACC_W=12 and ACC_W=6) fed the same stream,
// expected frame totals come from a behavioural model through a scoreboard queue.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        out_ready;
    logic [4:0]  sum_in;

    logic        rdy12, ov12, ovf12, busy12;
    logic [11:0] acc12;
    logic        rdy6, ov6, ovf6, busy6;
    logic [5:0]  acc6;

    always #5 clk = ~clk;

    sum_accumulator #(.IN_W(5), .ACC_W(12), .COUNT(4)) dut12 (
        .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in), .in_valid(in_valid),
        .in_ready(rdy12), .acc_out(acc12), .out_valid(ov12), .out_ready(out_ready),
        .ovf(ovf12), .busy(busy12)
    );

    sum_accumulator #(.IN_W(5), .ACC_W(6), .COUNT(4)) dut6 (
        .clk(clk), .rst(rst), .clr(clr), .sum_in(sum_in), .in_valid(in_valid),
        .in_ready(rdy6), .acc_out(acc6), .out_valid(ov6), .out_ready(out_ready),
        .ovf(ovf6), .busy(busy6)
    );

    typedef struct {
        int a12;
        int o12;
        int a6;
        int o6;
    } exp_t;

    exp_t sbq[$];
    int   m12, o12, m6, o6, mcnt;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference add: wrap or clamp at 2^w, overflow is sticky within the frame.
    function automatic void madd(inout int acc, inout int ov, input int v, input int w);
        int s;
        s = acc + v;
        if (s >= (1 << w)) begin
            ov = 1;
`ifdef SUM_ACC_SATURATE_EN
            s = (1 << w) - 1;
`else
            s = s - (1 << w);
`endif
        end
        acc = s;
    endfunction

    task automatic model_push(input int v);
        if (mcnt == 0) begin
            m12 = v; m6 = v; o12 = 0; o6 = 0;
        end else begin
            madd(m12, o12, v, 12);
            madd(m6, o6, v, 6);
        end
        mcnt++;
        if (mcnt == 4) begin
            sbq.push_back('{m12, o12, m6, o6});
            mcnt = 0;
        end
    endtask

    // Offer one sample; it transfers on the next rising edge.
    task automatic push(input int v);
        @(negedge clk);
        in_valid = 1'b1;
        sum_in   = 5'(v);
        #1;
        chk("in_ready12", rdy12, 1);
        chk("in_ready6", rdy6, 1);
        model_push(v);
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("busy_gap", busy12, 1);
        end
    endtask

    // Wait for a total, hold it for 'hold' cycles with a sample offered, then take it.
    task automatic take(input int hold);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov12 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid12", ov12, 1);
        chk("out_valid6", ov6, 1);
        chk("sb_depth", sbq.size(), 1);
        if (sbq.size() > 0) e = sbq.pop_front();
        else e = '{-1, -1, -1, -1};
        chk("acc12", acc12, e.a12);
        chk("ovf12", ovf12, e.o12);
        chk("acc6", acc6, e.a6);
        chk("ovf6", ovf6, e.o6);
        chk("busy_done", busy12, 0);
        repeat (hold) begin
            in_valid = 1'b1;
            sum_in   = 5'd9;
            #1;
            chk("hold_in_ready", rdy12, 0);
            @(negedge clk);
            chk("hold_out_valid", ov12, 1);
            chk("hold_acc12", acc12, e.a12);
            chk("hold_ovf6", ovf6, e.o6);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("out_valid_drop", ov12, 0);
        chk("in_ready_idle", rdy12, 1);
        chk("acc12_kept", acc12, e.a12);
        chk("busy_idle", busy12, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_in = '0;
        mcnt = 0; m12 = 0; o12 = 0; m6 = 0; o6 = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", rdy12, 0);
        chk("rst_acc", acc12, 0);
        chk("rst_out_valid", ov12, 0);
        chk("rst_ovf", ovf12, 0);
        chk("rst_busy", busy12, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", rdy12, 1);

        // Back-to-back frame 5,10,31,1 -> 47.
        push(5); push(10); push(31); push(1);
        take(0);

        // Same frame with two idle cycles between samples.
        push(5); gap(2); push(10); gap(2); push(31); gap(2); push(1);
        take(0);

        // Total held for three cycles while a sample is offered and refused.
        push(5); push(10); push(31); push(1);
        take(3);

        // Overflow on the 6-bit instance, then a clean frame clears ovf.
        push(31); push(31); push(31); push(31);
        take(0);
        push(1); gap(1);
        @(negedge clk);
        chk("ovf6_cleared", ovf6, 0);
        push(1); push(1); push(1);
        take(0);

        // Abort a partial frame with clr.
        push(7); push(7);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; sum_in = 5'd7;
        #1;
        chk("clr_in_ready", rdy12, 0);
        mcnt = 0;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        #1;
        chk("clr_acc", acc12, 0);
        chk("clr_busy", busy12, 0);
        chk("clr_out_valid", ov12, 0);
        chk("clr_in_ready_after", rdy12, 1);
        push(1); push(2); push(3); push(4);
        take(0);

        // Reset while a total waits in DONE.
        push(31); push(31); push(31); push(31);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", ov12, 1);
        chk("pre_rst_ovf6", ovf6, 1);
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", rdy12, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sbq.delete();
        mcnt = 0;
        chk("rst_done_out_valid", ov12, 0);
        chk("rst_done_acc12", acc12, 0);
        chk("rst_done_acc6", acc6, 0);
        chk("rst_done_ovf6", ovf6, 0);
        chk("rst_done_in_ready", rdy12, 1);

        // Clean frame after reset.
        push(2); push(2); push(2); push(2);
        take(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
